// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-organised internal memory.
// Independent read and write state machines; FIXED/INCR bursts with byte strobes.
module axi_sram_slave #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        areset,
    // read address channel
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    // read data channel
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address channel
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    // write data channel
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response channel
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [1:0]  BURST_INCR  = 2'b01;

    typedef enum logic {R_IDLE, R_DATA} rstate_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

    logic [31:0] mem_q [MEM_WORDS];

    logic unused_inputs;
    assign unused_inputs = ^{wid, arlock, arcache, arprot, awlock, awcache, awprot};

    // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
    function automatic logic [1:0] beat_resp(input logic [31:0] addr,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
        if (size > 3'd2 || burst[1]) return RESP_SLVERR;
        else if ((addr - BASE_ADDR) >= WIN_BYTES) return RESP_DECERR;
        else return RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        return (burst == BURST_INCR) ? addr + (32'd1 << size) : addr;
    endfunction

    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // ---------------- read channel ----------------
    rstate_e     r_state_q, r_state_d;
    logic [3:0]  rid_q, rid_d;
    logic [31:0] raddr_q, raddr_d;
    logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]  rsize_q, rsize_d;
    logic [1:0]  rburst_q, rburst_d;
    logic [1:0]  r_beat_resp;

    always_comb begin
        r_state_d   = r_state_q;
        rid_d       = rid_q;
        raddr_d     = raddr_q;
        rlen_d      = rlen_q;
        rcnt_d      = rcnt_q;
        rsize_d     = rsize_q;
        rburst_d    = rburst_q;
        arready     = 1'b0;
        rvalid      = 1'b0;
        rlast       = 1'b0;
        rresp       = RESP_OKAY;
        rdata       = '0;
        rid         = rid_q;
        r_beat_resp = beat_resp(raddr_q, rsize_q, rburst_q);
        unique case (r_state_q)
            R_IDLE: begin
                arready = !areset;
                if (arvalid && arready) begin
                    rid_d     = arid;
                    raddr_d   = araddr;
                    rlen_d    = arlen;
                    rsize_d   = arsize;
                    rburst_d  = arburst;
                    rcnt_d    = '0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (rcnt_q == rlen_q);
                rresp  = r_beat_resp;
                rdata  = (r_beat_resp == RESP_OKAY) ? mem_q[word_idx(raddr_q)] : '0;
                if (rready) begin
                    rcnt_d  = rcnt_q + 8'd1;
                    raddr_d = next_addr(raddr_q, rsize_q, rburst_q);
                    if (rlast) r_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
        end
    end

    // ---------------- write channel ----------------
    wstate_e     w_state_q, w_state_d;
    logic [3:0]  bid_q, bid_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]  wsize_q, wsize_d;
    logic [1:0]  wburst_q, wburst_d;
    logic [1:0]  werr_q, werr_d;
    logic        wover_q, wover_d;
    logic [1:0]  w_beat_resp;
    logic [1:0]  werr_n;
    logic        mem_we;
    logic [IDX_W-1:0] mem_widx;

    always_comb begin
        w_state_d   = w_state_q;
        bid_d       = bid_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wcnt_d      = wcnt_q;
        wsize_d     = wsize_q;
        wburst_d    = wburst_q;
        werr_d      = werr_q;
        wover_d     = wover_q;
        werr_n      = werr_q;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        bresp       = RESP_OKAY;
        bid         = bid_q;
        mem_we      = 1'b0;
        w_beat_resp = beat_resp(waddr_q, wsize_q, wburst_q);
        mem_widx    = word_idx(waddr_q);
        unique case (w_state_q)
            W_IDLE: begin
                awready = !areset;
                if (awvalid && awready) begin
                    bid_d     = awid;
                    waddr_d   = awaddr;
                    wlen_d    = awlen;
                    wsize_d   = awsize;
                    wburst_d  = awburst;
                    wcnt_d    = '0;
                    werr_d    = RESP_OKAY;
                    wover_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    wcnt_d  = wcnt_q + 8'd1;
                    waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
                    // Once beat len passed without wlast, further beats are drained unseen.
                    if (!wover_q) begin
                        mem_we = (w_beat_resp == RESP_OKAY);
                        werr_n = worst_resp(werr_q, w_beat_resp);
                        if (wlast && wcnt_q != wlen_q) werr_n = worst_resp(werr_n, RESP_SLVERR);
                        if (!wlast && wcnt_q == wlen_q) begin
                            werr_n  = worst_resp(werr_n, RESP_SLVERR);
                            wover_d = 1'b1;
                        end
                        werr_d = werr_n;
                    end
                    if (wlast) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = werr_q;
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            bid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            werr_q    <= RESP_OKAY;
            wover_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            bid_q     <= bid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            werr_q    <= werr_d;
            wover_q   <= wover_d;
        end
    end

    // Memory is deliberately outside reset so committed data survives it.
    always_ff @(posedge aclk) begin
        if (mem_we && !areset) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (wstrb[k[1:0]]) mem_q[mem_widx][{k[1:0], 3'b000} +: 8] <= wdata[{k[1:0], 3'b000} +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: spec-level memory/response model
// plus a per-cycle compare process and literal checks from the test plan.
module tb_axi_sram_slave;

    localparam int unsigned MW   = 256;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  arid, awid, wid;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, awvalid, awready;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic        rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;

    axi_sram_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rbeat_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } bbeat_t;

    int     vectors = 0;
    int     miscompares = 0;
    rbeat_t exp_r[$], got_r[$];
    bbeat_t exp_b[$], got_b[$];
    bit     r_busy = 1'b0;
    int     w_phase = 0;      // 0 idle, 1 accepting data, 2 response pending
    bit     rr_toggle = 1'b0;
    logic [31:0] mm [int unsigned];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait expired, got timeout, want handshake", name);
    endtask

    // ---- behavioural model ----
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst, input int i);
        logic [63:0] t;
        if (burst == 2'b00) return a;
        t = {32'b0, a} + 64'(i) * (64'd1 << size);
        return t[31:0];
    endfunction

    function automatic logic [1:0] m_err(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
        logic [63:0] lo, hi;
        if (size > 3'd2 || burst == 2'b10 || burst == 2'b11) return 2'b10;
        lo = {32'b0, BASE};
        hi = lo + 64'(MW) * 64'd4;
        if ({32'b0, a} < lo || {32'b0, a} >= hi) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'b11 || b == 2'b11) return 2'b11;
        if (a == 2'b10 || b == 2'b10) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int unsigned m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        return mm.exists(m_idx(a)) ? mm[m_idx(a)] : 32'h0;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = m_read(a);
        for (int k = 0; k < 4; k++) if (s[k]) w[8*k +: 8] = d[8*k +: 8];
        mm[m_idx(a)] = w;
    endtask

    // ---- drivers ----
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        logic [1:0]  e;
        bit ok;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, size, burst, i);
            e = m_err(a, size, burst);
            exp_r.push_back('{data: (e == 2'b00) ? m_read(a) : 32'h0, resp: e, last: (i == int'(len)), id: id});
        end
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 64 && !ok; c++) begin @(negedge aclk); ok = (arready === 1'b1); end
        if (!ok) timeout("ar_wait");
        @(posedge aclk); #1;
        arvalid = 1'b0;
        r_busy = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 1000 && !ok; c++) begin @(posedge aclk); #1; ok = !r_busy; end
        if (!ok) begin timeout("r_burst"); r_busy = 1'b0; exp_r.delete(); end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nb, input int bwait);
        logic [31:0] a;
        logic [1:0]  e, acc;
        bit over, ok;
        acc = 2'b00; over = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (!over) begin
                a = beat_addr(addr, size, burst, b);
                e = m_err(a, size, burst);
                if (e == 2'b00) m_write(a, wd[b], ws[b]);
                acc = worst(acc, e);
                if (b == nb - 1 && b != int'(len)) acc = worst(acc, 2'b10);
                if (b != nb - 1 && b == int'(len)) begin acc = worst(acc, 2'b10); over = 1'b1; end
            end
        end
        exp_b.push_back('{id: id, resp: acc});
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 64 && !ok; c++) begin @(negedge aclk); ok = (awready === 1'b1); end
        if (!ok) timeout("aw_wait");
        @(posedge aclk); #1;
        awvalid = 1'b0;
        w_phase = 1;
        for (int b = 0; b < nb; b++) begin
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == nb - 1); wvalid = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 64 && !ok; c++) begin @(negedge aclk); ok = (wready === 1'b1); end
            if (!ok) timeout("w_wait");
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        w_phase = 2;
        for (int c = 0; c < bwait; c++) begin @(posedge aclk); #1; end
        bready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 64 && !ok; c++) begin @(posedge aclk); #1; ok = (w_phase == 0); end
        bready = 1'b0;
        if (!ok) begin timeout("b_wait"); w_phase = 0; exp_b.delete(); end
    endtask

    task automatic wr1(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        wd[0] = d; ws[0] = s;
        do_write(id, addr, 8'd0, 3'd2, 2'b01, 1, 0);
    endtask

    // ---- per-cycle compare against the model ----
    initial begin
        forever begin
            @(negedge aclk);
            if (areset !== 1'b0) continue;
            chk("arready", 32'(arready), 32'(!r_busy));
            chk("awready", 32'(awready), 32'(w_phase == 0));
            chk("rvalid",  32'(rvalid),  32'(r_busy));
            chk("wready",  32'(wready),  32'(w_phase == 1));
            chk("bvalid",  32'(bvalid),  32'(w_phase == 2));
            if (r_busy) begin
                if (exp_r.size() == 0) timeout("r_model_empty");
                else begin
                    chk("rdata", rdata, exp_r[0].data);
                    chk("rresp", 32'(rresp), 32'(exp_r[0].resp));
                    chk("rlast", 32'(rlast), 32'(exp_r[0].last));
                    chk("rid",   32'(rid),   32'(exp_r[0].id));
                    if (rready) begin
                        got_r.push_back('{data: rdata, resp: rresp, last: rlast, id: rid});
                        if (exp_r[0].last) r_busy = 1'b0;
                        void'(exp_r.pop_front());
                    end
                end
            end
            if (w_phase == 2) begin
                if (exp_b.size() == 0) timeout("b_model_empty");
                else begin
                    chk("bid",   32'(bid),   32'(exp_b[0].id));
                    chk("bresp", 32'(bresp), 32'(exp_b[0].resp));
                    if (bready) begin
                        got_b.push_back('{id: bid, resp: bresp});
                        void'(exp_b.pop_front());
                        w_phase = 0;
                    end
                end
            end
        end
    end

    initial begin
        rready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            rready = rr_toggle ? !rready : 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        arlock = '0; arcache = '0; arprot = '0; awlock = '0; awcache = '0; awprot = '0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_arready", 32'(arready), 0); chk("rst_awready", 32'(awready), 0);
        chk("rst_rvalid", 32'(rvalid), 0);   chk("rst_wready", 32'(wready), 0);
        chk("rst_bvalid", 32'(bvalid), 0);   chk("rst_rlast", 32'(rlast), 0);
        chk("rst_rresp", 32'(rresp), 0);     chk("rst_bresp", 32'(bresp), 0);
        chk("rst_rid", 32'(rid), 0);         chk("rst_bid", 32'(bid), 0);
        chk("rst_rdata", rdata, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;

        // single read
        wr1(4'd1, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
        got_r.delete();
        do_read(4'd3, BASE + 32'h10, 8'd0, 3'd2, 2'b01);
        chk("single_data", got_r[0].data, 32'hDEADBEEF);
        chk("single_resp", 32'(got_r[0].resp), 0);
        chk("single_last", 32'(got_r[0].last), 1);
        chk("single_id", 32'(got_r[0].id), 3);

        // INCR write burst then read-back
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        got_b.delete();
        do_write(4'd5, BASE + 32'h20, 8'd3, 3'd2, 2'b01, 4, 0);
        chk("incr_bid", 32'(got_b[0].id), 5);
        chk("incr_bresp", 32'(got_b[0].resp), 0);
        got_r.delete();
        do_read(4'd2, BASE + 32'h20, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rd_data", got_r[i].data, 32'(i + 1));
            chk("incr_rd_last", 32'(got_r[i].last), 32'(i == 3));
        end
        // narrow INCR read stays in one word
        do_read(4'd2, BASE + 32'h20, 8'd3, 3'd0, 2'b01);

        // byte strobes
        wr1(4'd1, BASE, 32'h11223344, 4'hF);
        wr1(4'd1, BASE, 32'hAABBCCDD, 4'b0101);
        got_r.delete();
        do_read(4'd0, BASE, 8'd0, 3'd2, 2'b01);
        chk("strobe_data", got_r[0].data, 32'h11BB33DD);

        // out of range and window edges
        got_r.delete();
        do_read(4'd4, BASE + 32'(MW * 4), 8'd0, 3'd2, 2'b01);
        chk("oor_rresp", 32'(got_r[0].resp), 32'h3);
        chk("oor_rdata", got_r[0].data, 0);
        do_read(4'd4, BASE - 32'd4, 8'd0, 3'd2, 2'b01);
        got_b.delete();
        wr1(4'd6, BASE + 32'(MW * 4), 32'hFFFFFFFF, 4'hF);
        chk("oor_bresp", 32'(got_b[0].resp), 32'h3);
        got_r.delete();
        do_read(4'd0, BASE, 8'd0, 3'd2, 2'b01);
        chk("oor_mem_kept", got_r[0].data, 32'h11BB33DD);
        wr1(4'd1, BASE + 32'(MW * 4) - 32'd4, 32'hCAFEF00D, 4'hF);
        do_read(4'd1, BASE + 32'(MW * 4) - 32'd4, 8'd1, 3'd2, 2'b01);

        // protocol errors
        wd[0] = 32'h0000_0055; ws[0] = 4'hF;
        got_b.delete();
        do_write(4'd8, BASE + 32'h30, 8'd1, 3'd2, 2'b01, 1, 0);
        chk("early_wlast_bresp", 32'(got_b[0].resp), 32'h2);
        wd[0] = 32'h0000_0040; wd[1] = 32'h0000_0041; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'd9, BASE + 32'h40, 8'd0, 3'd2, 2'b01, 2, 0);
        do_read(4'd1, BASE + 32'h40, 8'd1, 3'd2, 2'b01);
        got_r.delete();
        do_read(4'd3, BASE + 32'h10, 8'd0, 3'd3, 2'b01);
        chk("size3_rresp", 32'(got_r[0].resp), 32'h2);
        do_read(4'd3, BASE + 32'h10, 8'd1, 3'd2, 2'b10);
        for (int i = 0; i < 3; i++) begin wd[i] = 32'hF0 + 32'(i); ws[i] = 4'hF; end
        do_write(4'd2, BASE + 32'h50, 8'd2, 3'd2, 2'b00, 3, 0);
        do_read(4'd2, BASE + 32'h50, 8'd2, 3'd2, 2'b00);

        // concurrency with backpressure
        for (int i = 0; i < 8; i++) begin wd[i] = 32'h100 + 32'(i); ws[i] = 4'hF; end
        do_write(4'd3, BASE + 32'h100, 8'd7, 3'd2, 2'b01, 8, 0);
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h200 + 32'(i); ws[i] = 4'hF; end
        rr_toggle = 1'b1;
        fork
            do_read(4'd7, BASE + 32'h100, 8'd7, 3'd2, 2'b01);
            do_write(4'd4, BASE + 32'h200, 8'd3, 3'd2, 2'b01, 4, 5);
        join
        rr_toggle = 1'b0;
        do_read(4'd7, BASE + 32'h200, 8'd3, 3'd2, 2'b01);

        // reset in the middle of a write burst
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h0; ws[i] = 4'hF; end
        do_write(4'd0, BASE + 32'h300, 8'd3, 3'd2, 2'b01, 4, 0);
        awid = 4'd7; awaddr = BASE + 32'h300; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; w_phase = 1;
        wdata = 32'hA0A0A0A0; wstrb = 4'hF; wvalid = 1'b1;
        m_write(BASE + 32'h300, 32'hA0A0A0A0, 4'hF);
        @(posedge aclk); #1;
        wdata = 32'hA1A1A1A1;
        m_write(BASE + 32'h304, 32'hA1A1A1A1, 4'hF);
        @(posedge aclk); #1;
        wvalid = 1'b0; areset = 1'b1;
        @(posedge aclk); #1;
        w_phase = 0;
        @(negedge aclk);
        chk("midrst_awready", 32'(awready), 0);
        chk("midrst_wready", 32'(wready), 0);
        chk("midrst_bvalid", 32'(bvalid), 0);
        chk("midrst_bid", 32'(bid), 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        got_r.delete();
        do_read(4'd1, BASE + 32'h300, 8'd3, 3'd2, 2'b01);
        chk("midrst_kept0", got_r[0].data, 32'hA0A0A0A0);
        chk("midrst_kept1", got_r[1].data, 32'hA1A1A1A1);
        chk("midrst_untouched", got_r[2].data, 32'h0);

        repeat (2) @(posedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 slave responder that backs a 32-bit address window with an internal word-organised memory. It answers the read and write requests that the CPU-side AXI master bridge issues, and it is used as the simulation and FPGA memory endpoint for the `arid`/`awid`/`wid` single-master bus. Read and write channels run in two independent state machines: one read burst and one write burst may be in flight at the same time. Both FIXED and INCR bursts are supported, with byte strobes and error responses for out-of-range or illegal requests.

## Interface
Parameters:
- MEM_WORDS, 1024, number of 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to MEM_WORDS*4.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  reset. Synchronous and active-high.
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read request fields. `arlock`, `arcache` and `arprot` are accepted and ignored.
- arvalid  in  1; arready  out  1.
- rid  out  4; rdata  out  32; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1.
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write request fields. `awlock`, `awcache` and `awprot` are ignored.
- awvalid  in  1; awready  out  1.
- wid  in  4 (ignored); wdata  in  32; wstrb  in  4; wlast  in  1; wvalid  in  1; wready  out  1.
- bid  out  4; bresp  out  2; bvalid  out  1; bready  in  1.

## Operation
- Word index: idx = (addr − BASE_ADDR) >> 2. A beat is in range when BASE_ADDR ≤ addr < BASE_ADDR + 4·MEM_WORDS.
- Per-burst error:
  - size > 2 → SLVERR (2'b10) on every beat.
  - arburst or awburst = 2'b10 (WRAP) or 2'b11 → SLVERR.
  - Otherwise, an out-of-range beat → DECERR (2'b11) for that beat.
  - Otherwise OKAY (2'b00).
- Beat address: FIXED keeps the captured address. INCR adds (1 << size) after each beat, with 32-bit wrap-around.
- Read FSM R_IDLE → R_DATA → R_IDLE:
  - R_IDLE: `arready` = 1. An AR handshake captures id, addr, len, size and burst, loads the beat counter with 0, and goes to R_DATA.
  - R_DATA: `rvalid` = 1 and `rdata` = mem[idx] of the current beat. Erroring beats drive `rdata` = 0. `rlast` = (count == len). `rid` = captured id.
  - On an R handshake the counter and address advance. A handshake with `rlast` returns the FSM to R_IDLE.
  - `rdata`, `rresp` and `rlast` stay stable while `rvalid` is high and `rready` is low.
- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: `awready` = 1. An AW handshake captures id, addr, len, size and burst, clears the beat counter and an error flag, and goes to W_DATA.
  - W_DATA: `wready` = 1. On each W handshake, if the beat has no error, mem[idx] byte k ← wdata[8k+7:8k] for every set wstrb[k]. Erroring beats are dropped. The worst error seen is accumulated (DECERR over SLVERR over OKAY).
  - A W handshake with `wlast` goes to W_RESP. `wlast` arriving before beat len, or beat len arriving without `wlast`, sets SLVERR. In the second case the slave keeps accepting beats until `wlast`, then discards them.
  - W_RESP: `bvalid` = 1, `bid` = captured id, `bresp` = accumulated error. A B handshake returns the FSM to W_IDLE.
- Narrow reads return the full aligned word; the master selects the byte lanes.
- Memory contents are not cleared by reset. The simulation initial value is 0.

## Timing
- Reset values (asserted during and for the cycle after `areset`): `arready` = `awready` = 0, `rvalid` = `wready` = `bvalid` = 0, `rlast` = 0, `rresp` = `bresp` = 0, `rid` = `bid` = 0, `rdata` = 0.
- First cycle after reset release: FSMs are in their IDLE states, and `arready` and `awready` rise.
- Reset mid-burst: both FSMs return to IDLE immediately. Pending responses are dropped, and any partial write already committed stays in memory.
- Read latency: AR handshake at cycle T gives `rvalid` at T+1. The burst runs one beat per cycle while `rready` = 1. The last handshake at cycle L is followed by `arready` at L+1.
- Write latency: AW handshake at T gives `wready` at T+1. `wready` is 0 in W_IDLE, so W data offered alongside AW waits one cycle. `wlast` handshake at cycle L gives `bvalid` at L+1, and the B handshake at cycle B gives `awready` at B+1.
- Simultaneous read and write to the same word in one cycle: the read beat returns the old data, and the write takes effect the next cycle.
- Each channel has exactly one outstanding transaction. The `ready` outputs are low while that channel is busy.

## Test plan
- Single read: after writing 32'hDEADBEEF at BASE+0x10, issue AR addr=BASE+0x10, len=0, size=2, id=3 → `rvalid` the cycle after AR, `rdata` = 32'hDEADBEEF, `rresp` = 0, `rlast` = 1, `rid` = 3.
- INCR write burst: AW addr=BASE+0x20, len=3, id=5, four beats 1, 2, 3, 4 with `wstrb` = 4'hF and `wlast` on beat 4 → `bresp` = 0, `bid` = 5. A read-back with len=3 returns 1, 2, 3, 4, with `rlast` on the 4th beat only.
- Byte strobe: word at BASE = 32'h11223344; write 32'hAABBCCDD with `wstrb` = 4'b0101 → read-back gives 32'h11BB33DD.
- Out of range: read at BASE + 4·MEM_WORDS → `rresp` = 2'b11, `rdata` = 0. Write at the same address → `bresp` = 2'b11, and memory is unchanged.
- Protocol error: AW len=1 with `wlast` on beat 0 → `bresp` = 2'b10. AR with size = 3 → `rresp` = 2'b10.
- Concurrency and backpressure: a read burst with len=7 while a write burst is active, `rready` toggling 1010… and `bready` held low for 5 cycles → `rdata` is held stable while stalled, both bursts complete correctly, and `awready` stays 0 until the B handshake.
